// File: rtl/brushless_pkg.sv
`default_nettype none
// ============================================================================
// Module  : brushless_pkg
// Brief   : Phase-mode type, legal sector codes and sector/gate decode helpers
// Revision: 1.0
// ============================================================================
package brushless_pkg;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    FWD = 2'd1,
    REV = 2'd2
  } phase_mode_t;

  typedef struct packed {
    phase_mode_t grn;
    phase_mode_t ylw;
    phase_mode_t blu;
  } phase_modes_t;

  localparam logic [2:0] c_SECT_101 = 3'b101;
  localparam logic [2:0] c_SECT_100 = 3'b100;
  localparam logic [2:0] c_SECT_110 = 3'b110;
  localparam logic [2:0] c_SECT_010 = 3'b010;
  localparam logic [2:0] c_SECT_011 = 3'b011;
  localparam logic [2:0] c_SECT_001 = 3'b001;

  function automatic logic sector_legal(input logic [2:0] sect);
    return (sect != 3'b000) && (sect != 3'b111);
  endfunction

  function automatic phase_modes_t sector_to_modes(input logic [2:0] sect);
    phase_modes_t m;
    m.grn = OFF;
    m.ylw = OFF;
    m.blu = OFF;
    case (sect)
      c_SECT_101: begin m.grn = FWD; m.ylw = REV; end
      c_SECT_100: begin m.grn = FWD; m.blu = REV; end
      c_SECT_110: begin m.ylw = FWD; m.blu = REV; end
      c_SECT_010: begin m.grn = REV; m.ylw = FWD; end
      c_SECT_011: begin m.grn = REV; m.blu = FWD; end
      c_SECT_001: begin m.ylw = REV; m.blu = FWD; end
      default:    ;
    endcase
    return m;
  endfunction

  // Returns {high, low}; braking shorts every phase through its low side.
  function automatic logic [1:0] phase_gates(input phase_mode_t mode, input logic pwm1,
                                             input logic pwm2, input logic brake_n);
    logic [1:0] g;
    g = 2'b00;
    if (!brake_n) begin
      g = {1'b0, pwm2};
    end else begin
      case (mode)
        FWD:     g = {pwm1, pwm2};
        REV:     g = {pwm2, pwm1};
        default: g = 2'b00;
      endcase
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hall_sync.sv
`default_nettype none
// ============================================================================
// Module  : hall_sync
// Brief   : SYNC_STAGES-deep flop chain for one asynchronous hall sensor
// Revision: 1.0
// ============================================================================
module hall_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/brushless_comm.sv
`default_nettype none
// ============================================================================
// Module  : brushless_comm
// Brief   : Hall-sector commutation, regen brake and commutation-period timer
// Revision: 1.0
// ============================================================================
module brushless_comm
  import brushless_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hallGrn,
  input  logic                hallYlw,
  input  logic                hallBlu,
  input  logic                PWM1,
  input  logic                PWM2,
  input  logic                PWM_synch,
  input  logic                brake_n,
  output logic                highGrn,
  output logic                lowGrn,
  output logic                highYlw,
  output logic                lowYlw,
  output logic                highBlu,
  output logic                lowBlu,
  output logic [2:0]          rot_state,
  output logic                hall_err,
  output logic [PERIOD_W-1:0] comm_period,
  output logic                comm_vld,
  output logic                stall
);

  localparam logic [PERIOD_W-1:0] c_CNT_MAX = '1;

  logic [2:0]          hall_s;
  logic [2:0]          rot_q, rot_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                vld_q, vld_d;
  logic                stall_q, stall_d;
  logic [5:0]          gates_q, gates_d;
  phase_modes_t        modes;

  hall_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_grn (
    .clk(clk), .rst(rst), .async_i(hallGrn), .sync_o(hall_s[2]));
  hall_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ylw (
    .clk(clk), .rst(rst), .async_i(hallYlw), .sync_o(hall_s[1]));
  hall_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_blu (
    .clk(clk), .rst(rst), .async_i(hallBlu), .sync_o(hall_s[0]));

  // The reported period is the elapsed clock count including the sampling edge.
  always_comb begin
    cnt_inc  = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    rot_d    = rot_q;
    cnt_d    = cnt_inc;
    period_d = period_q;
    vld_d    = 1'b0;
    stall_d  = stall_q;
    if (PWM_synch) begin
      rot_d = hall_s;
      if (sector_legal(hall_s) && (hall_s != rot_q)) begin
        cnt_d = '0;
        if (sector_legal(rot_q)) begin
          period_d = cnt_inc;
          vld_d    = 1'b1;
          stall_d  = 1'b0;
        end
      end
    end
    if (cnt_d == c_CNT_MAX) begin
      stall_d = 1'b1;
    end
  end

  always_comb begin
    modes   = sector_to_modes(rot_q);
    gates_d = {phase_gates(modes.grn, PWM1, PWM2, brake_n),
               phase_gates(modes.ylw, PWM1, PWM2, brake_n),
               phase_gates(modes.blu, PWM1, PWM2, brake_n)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rot_q    <= 3'b000;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      stall_q  <= 1'b0;
      gates_q  <= 6'b000000;
    end else begin
      rot_q    <= rot_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      stall_q  <= stall_d;
      gates_q  <= gates_d;
    end
  end

  assign {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu} = gates_q;
  assign rot_state   = rot_q;
  assign hall_err    = !sector_legal(rot_q);
  assign comm_period = period_q;
  assign comm_vld    = vld_q;
  assign stall       = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_brushless_comm.sv
`default_nettype none
// ============================================================================
// Module  : tb_brushless_comm
// Brief   : Directed self-checking bench for brushless_comm (16-bit and 8-bit)
// Revision: 1.0
// ============================================================================
module tb_brushless_comm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hallGrn = 1'b0, hallYlw = 1'b0, hallBlu = 1'b0;
  logic PWM1 = 1'b0, PWM2 = 1'b0, PWM_synch = 1'b0, brake_n = 1'b1;
  logic hallGrn8 = 1'b1, hallYlw8 = 1'b0, hallBlu8 = 1'b1, synch8 = 1'b0;

  logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu;
  logic [2:0]  rot_state;
  logic        hall_err, comm_vld, stall;
  logic [15:0] comm_period;
  logic        hG8, lG8, hY8, lY8, hB8, lB8;
  logic [2:0]  rot8;
  logic        err8, vld8, stall8;
  logic [7:0]  period8;
  logic [5:0]  gates;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign gates = {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu};

  brushless_comm #(.PERIOD_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .PWM1(PWM1), .PWM2(PWM2), .PWM_synch(PWM_synch), .brake_n(brake_n),
    .highGrn(highGrn), .lowGrn(lowGrn), .highYlw(highYlw), .lowYlw(lowYlw),
    .highBlu(highBlu), .lowBlu(lowBlu), .rot_state(rot_state), .hall_err(hall_err),
    .comm_period(comm_period), .comm_vld(comm_vld), .stall(stall));

  brushless_comm #(.PERIOD_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .hallGrn(hallGrn8), .hallYlw(hallYlw8), .hallBlu(hallBlu8),
    .PWM1(PWM1), .PWM2(PWM2), .PWM_synch(synch8), .brake_n(brake_n),
    .highGrn(hG8), .lowGrn(lG8), .highYlw(hY8), .lowYlw(lY8),
    .highBlu(hB8), .lowBlu(lB8), .rot_state(rot8), .hall_err(err8),
    .comm_period(period8), .comm_vld(vld8), .stall(stall8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    PWM_synch = 1'b1;
    @(negedge clk);
    PWM_synch = 1'b0;
  endtask

  task automatic set_halls(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
  endtask

  // High and low of a phase must never be on together.
  always @(negedge clk) begin
    chk("shoot_thru",
        {31'd0, (highGrn & lowGrn) | (highYlw & lowYlw) | (highBlu & lowBlu) |
                (hG8 & lG8) | (hY8 & lY8) | (hB8 & lB8)}, 32'd0);
  end

  initial begin
    cyc(3);
    chk("rst_gates", {26'd0, gates}, 32'h00);
    chk("rst_rot", {29'd0, rot_state}, 32'd0);
    chk("rst_err", {31'd0, hall_err}, 32'd1);
    chk("rst_period", {16'd0, comm_period}, 32'd0);
    chk("rst_vld", {31'd0, comm_vld}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Sector 101: Grn FWD, Ylw REV, Blu OFF
    set_halls(3'b101); PWM1 = 1'b1; PWM2 = 1'b0;
    cyc(3);
    pulse();
    chk("s101_rot", {29'd0, rot_state}, 32'b101);
    chk("s101_err", {31'd0, hall_err}, 32'd0);
    chk("s101_novld", {31'd0, comm_vld}, 32'd0);
    cyc(1);
    chk("s101_g_p1", {26'd0, gates}, 32'b10_01_00);
    PWM1 = 1'b0; PWM2 = 1'b1;
    cyc(1);
    chk("s101_g_p2", {26'd0, gates}, 32'b01_10_00);

    // Mid-period hall change must not reach the gates before PWM_synch
    PWM1 = 1'b1; PWM2 = 1'b0;
    set_halls(3'b100);
    cyc(4);
    chk("hold_gates", {26'd0, gates}, 32'b10_01_00);
    chk("hold_rot", {29'd0, rot_state}, 32'b101);
    pulse();
    chk("s100_vld", {31'd0, comm_vld}, 32'd1);
    chk("s100_rot", {29'd0, rot_state}, 32'b100);
    cyc(1);
    chk("s100_vld_once", {31'd0, comm_vld}, 32'd0);
    chk("s100_gates", {26'd0, gates}, 32'b10_00_01);

    // Next latched change exactly 500 clocks later
    set_halls(3'b110);
    cyc(498);
    pulse();
    chk("s110_vld", {31'd0, comm_vld}, 32'd1);
    chk("s110_period", {16'd0, comm_period}, 32'd500);
    cyc(1);
    chk("s110_vld_once", {31'd0, comm_vld}, 32'd0);
    chk("s110_gates", {26'd0, gates}, 32'b00_10_01);

    // Illegal sector 111
    set_halls(3'b111);
    cyc(3);
    pulse();
    chk("s111_novld", {31'd0, comm_vld}, 32'd0);
    chk("s111_err", {31'd0, hall_err}, 32'd1);
    cyc(1);
    chk("s111_gates", {26'd0, gates}, 32'h00);
    brake_n = 1'b0; PWM1 = 1'b0; PWM2 = 1'b1;
    cyc(1);
    chk("s111_brake", {26'd0, gates}, 32'b01_01_01);
    brake_n = 1'b1;
    cyc(1);
    chk("s111_unbrake", {26'd0, gates}, 32'h00);

    // Illegal -> legal restarts the counter without a period update
    set_halls(3'b010);
    cyc(3);
    pulse();
    chk("s010_novld", {31'd0, comm_vld}, 32'd0);
    chk("s010_rot", {29'd0, rot_state}, 32'b010);
    chk("s010_period_kept", {16'd0, comm_period}, 32'd500);
    cyc(1);
    chk("s010_gates", {26'd0, gates}, 32'b10_01_00);
    set_halls(3'b011);
    cyc(98);
    pulse();
    chk("s011_vld", {31'd0, comm_vld}, 32'd1);
    chk("s011_period", {16'd0, comm_period}, 32'd100);

    // Brake in sector 011 (Grn REV, Blu FWD)
    cyc(1);
    PWM1 = 1'b1; PWM2 = 1'b0; brake_n = 1'b0;
    cyc(1);
    chk("brk_p1", {26'd0, gates}, 32'h00);
    PWM1 = 1'b0; PWM2 = 1'b1;
    cyc(1);
    chk("brk_p2", {26'd0, gates}, 32'b01_01_01);
    brake_n = 1'b1;
    cyc(1);
    chk("brk_release", {26'd0, gates}, 32'b10_00_01);

    // Reset mid-operation
    rst = 1'b1;
    cyc(1);
    chk("mrst_gates", {26'd0, gates}, 32'h00);
    chk("mrst_rot", {29'd0, rot_state}, 32'd0);
    chk("mrst_err", {31'd0, hall_err}, 32'd1);
    chk("mrst_period", {16'd0, comm_period}, 32'd0);
    chk("mrst_stall8", {31'd0, stall8}, 32'd0);
    rst = 1'b0;

    // 8-bit period: saturation and stall
    cyc(3);
    synch8 = 1'b1;
    cyc(1);
    synch8 = 1'b0;
    chk("p8_rot", {29'd0, rot8}, 32'b101);
    cyc(254);
    chk("p8_stall_pre", {31'd0, stall8}, 32'd0);
    cyc(1);
    chk("p8_stall_set", {31'd0, stall8}, 32'd1);
    cyc(45);
    chk("p8_stall_hold", {31'd0, stall8}, 32'd1);
    {hallGrn8, hallYlw8, hallBlu8} = 3'b100;
    cyc(3);
    synch8 = 1'b1;
    cyc(1);
    synch8 = 1'b0;
    chk("p8_vld", {31'd0, vld8}, 32'd1);
    chk("p8_period", {24'd0, period8}, 32'd255);
    chk("p8_stall_clr", {31'd0, stall8}, 32'd0);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
